aes_round_ctrl: RTL
===================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `rst`: input, 1 bit, reset; synchronous, active-high.
REQ-003 The block SHALL have the port `in_valid`: input, 1 bit, a new block (plaintext plus cipher key) is offered.
REQ-004 The block SHALL have the port `in_ready`: output, 1 bit, the controller accepts a block.
REQ-005 The block SHALL have the port `key_valid`: input, 1 bit, the key schedule presents round key `round_idx`.
REQ-006 The block SHALL have the port `load_en`: output, 1 bit, the datapath captures plaintext into the state register.
REQ-007 The block SHALL have the ports `sb_en`, `sr_en`, `mc_en` and `ark_en`: outputs, 1 bit each, enabling the SubBytes, ShiftRows, MixColumns and AddRoundKey registers respectively.
REQ-008 The block SHALL have the port `round_idx`: output, 4 bits, the round-key index requested from the key schedule (0..10).
REQ-009 The block SHALL have the port `busy`: output, 1 bit, high in every state except IDLE.
REQ-010 The block SHALL have the port `out_valid`: output, 1 bit, the state register holds the finished ciphertext.
REQ-011 The block SHALL have the port `out_ready`: input, 1 bit, the consumer accepts the ciphertext.
REQ-012 With AES_ROUND_CTRL_ABORT_EN defined, the block SHALL have the port `abort`: input, 1 bit, cancels the block in flight.

Function
REQ-013 The FSM states SHALL be IDLE, INIT_ARK, SUB, SHIFT, MIX, ARK and DONE.
REQ-014 The outputs SHALL behave as follows:
- `in_ready` = (state==IDLE).
- Handshake occurs when `in_valid` and `in_ready` are both high.
- On handshake: `load_en`=1 for that cycle; next state INIT_ARK; `round_idx`<=0.
REQ-015 INIT_ARK SHALL behave as follows:
- `ark_en` = `key_valid`.
- If `key_valid`=1: go to SUB and set `round_idx`<=1.
- Otherwise hold INIT_ARK, with `ark_en` low.
REQ-016 SUB SHALL assert `sb_en` for one cycle and then go to SHIFT.
REQ-017 SHIFT SHALL assert `sr_en` for one cycle, then go to ARK if `round_idx`==10, otherwise go to MIX.
REQ-018 MIX SHALL assert `mc_en` for one cycle and then go to ARK; MIX is never entered in round 10.
REQ-019 ARK SHALL behave as follows:
- `ark_en` = `key_valid`.
- If `key_valid`=0: hold ARK.
- If `key_valid`=1 and `round_idx`==10: go to DONE.
- If `key_valid`=1 and `round_idx`<10: increment `round_idx` and go to SUB.
REQ-020 DONE SHALL behave as follows:
- `out_valid`=1.
- Hold DONE while `out_ready`=0.
- When `out_ready`=1: go to IDLE and set `round_idx`<=0.
- `in_ready` stays low in DONE.
REQ-021 The enables SHALL be mutually exclusive: at most one of `load_en`, `sb_en`, `sr_en`, `mc_en`, `ark_en` is high in any cycle.
REQ-022 `round_idx` SHALL never exceed 10 and SHALL change only on the transitions stated above.
REQ-023 Latency SHALL be as follows when `key_valid` is held high:
- Handshake in cycle t gives `out_valid` in cycle t+41.
- Rounds 1–9 take 4 cycles each, round 10 takes 3 cycles, and INIT_ARK takes 1 cycle.
- Each `key_valid`=0 cycle in INIT_ARK or ARK adds one cycle.
REQ-024 `in_valid` SHALL be ignored outside IDLE, and `key_valid` SHALL be ignored outside INIT_ARK and ARK.

Reset
REQ-025 When `rst`=1 at a clock edge, the block SHALL go to IDLE with `round_idx`=0, `out_valid`=0, `busy`=0 and all enables 0.
REQ-026 `rst` SHALL take priority over every other input, including mid-block; the block in flight is discarded with no `out_valid`.
REQ-027 In the first cycle after reset, `in_ready` SHALL be 1.

Configuration
REQ-028 With AES_ROUND_CTRL_ABORT_EN defined, `abort` SHALL behave as follows:
- `abort`=1 in any non-IDLE state sends the block to IDLE next cycle with `round_idx`=0.
- No enable is asserted in that cycle, and no `out_valid` is produced.
- `abort` is ignored in IDLE.
- `rst` takes priority over `abort`.
REQ-029 Without AES_ROUND_CTRL_ABORT_EN, the `abort` port SHALL be absent and behaviour SHALL be as in REQ-013..REQ-027.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Nominal: `key_valid`=1 and `out_ready`=1 always, handshake at cycle 5 -> `out_valid` at cycle 46 for exactly 1 cycle. Enable trace: `load_en`; `ark_en`; (`sb_en`, `sr_en`, `mc_en`, `ark_en`)x9; `sb_en`, `sr_en`, `ark_en`.
- Key stall: `key_valid`=0 for 3 cycles when first entering ARK with `round_idx`=4 -> FSM holds ARK with `ark_en`=0, `round_idx` stays 4, and `out_valid` is delayed by 3 cycles.
- Output backpressure: `out_ready`=0 for 5 cycles after DONE is reached -> `out_valid` held 6 cycles, `in_ready`=0 throughout, then IDLE.
- Mid-block reset: `rst`=1 while in MIX with `round_idx`=6 -> next cycle IDLE, `round_idx`=0, `busy`=0; a new handshake then completes normally.
- Round-10 boundary: check `mc_en` never asserts while `round_idx`=10 and `round_idx` never reaches 11, across 100 random-stall blocks.
- ABORT_EN build: `abort`=1 in SUB with `round_idx`=3 -> IDLE next cycle, no `out_valid`, `in_ready`=1.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences the AES-128 round datapath enables over ten rounds.
// Define AES_ROUND_CTRL_ABORT_EN to add the abort input that cancels a block in flight.
module aes_round_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       key_valid,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic       load_en,
    output logic       sb_en,
    output logic       sr_en,
    output logic       mc_en,
    output logic       ark_en,
    output logic [3:0] round_idx,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready
);
    typedef enum logic [2:0] {IDLE, INIT_ARK, SUB, SHIFT, MIX, ARK, DONE} state_t;
    state_t state;
    logic kill;
    logic last;
`ifdef AES_ROUND_CTRL_ABORT_EN
    assign kill = abort && state != IDLE;
`else
    assign kill = 1'b0;
`endif
    assign last = round_idx == 4'd10;
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            state     <= IDLE;
            round_idx <= 4'd0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state     <= INIT_ARK;
                    round_idx <= 4'd0;
                end
                INIT_ARK: if (key_valid) begin
                    state     <= SUB;
                    round_idx <= 4'd1;
                end
                SUB:   state <= SHIFT;
                SHIFT: state <= last ? ARK : MIX;
                MIX:   state <= ARK;
                ARK: if (key_valid) begin
                    state     <= last ? DONE : SUB;
                    round_idx <= last ? round_idx : round_idx + 4'd1;
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    round_idx <= 4'd0;
                end
                default: begin
                    state     <= IDLE;
                    round_idx <= 4'd0;
                end
            endcase
        end
    end
    // Enables are decoded from the state so that abort can suppress them in its own cycle.
    always_comb begin
        in_ready  = state == IDLE;
        busy      = state != IDLE;
        load_en   = in_ready && in_valid;
        sb_en     = state == SUB && !kill;
        sr_en     = state == SHIFT && !kill;
        mc_en     = state == MIX && !kill;
        ark_en    = (state == INIT_ARK || state == ARK) && key_valid && !kill;
        out_valid = state == DONE && !kill;
    end
endmodule
